// File: rtl/rmii_tx_framer.sv
// rtl/rmii_tx_framer.sv - RMII transmit framer: one 32-bit word becomes a padded Ethernet II frame with FCS
// Optional feature macro: TX_SEQNUM_EN (16-bit frame sequence number in payload bytes 4-5)
module rmii_tx_framer #(
  parameter logic [47:0] DEST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h6969_5A06_5491,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IPG_DIBITS = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [31:0] axiid,
  output logic        axiir,
  output logic        txen,
  output logic [1:0]  txd,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    HEADER,
    PAYLOAD,
    FCS,
    IPG
  } state_t;

  localparam logic [111:0] HDR      = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [7:0]   IPG_LAST = 8'(IPG_DIBITS - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  cnt;
  logic [7:0]  next_cnt;
  logic [31:0] word;
  logic [31:0] crc;
  logic [31:0] fcs_sh;
  logic [1:0]  next_dibit;
  logic [7:0]  pay_byte;
  logic [5:0]  pay_idx;
  logic        accept;
  logic        next_txen;
  logic        next_done;

`ifdef TX_SEQNUM_EN
  logic [15:0] seq;
`endif

  // Select dibit `sel` of a byte; bytes go out LSB dibit first
  function automatic logic [1:0] pick_dibit(input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] t;
    t = b >> {sel, 1'b0};
    return t[1:0];
  endfunction

  // Header byte `idx`, counting from the first byte on the wire
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    logic [111:0] t;
    t = HDR << {idx, 3'b000};
    return t[111:104];
  endfunction

  // Reflected CRC-32 advanced by one dibit, bit 0 of the dibit first
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign accept  = axiiv && axiir;
  assign pay_idx = next_cnt[7:2];

  // Next state and per-state dibit counter; the counter clears on every transition
  always_comb begin
    next_state = state;
    next_cnt   = cnt + 8'd1;
    unique case (state)
      IDLE: begin
        next_cnt = 8'd0;
        if (accept) next_state = PREAMBLE;
      end
      PREAMBLE: if (cnt == 8'd27)    begin next_state = SFD;     next_cnt = 8'd0; end
      SFD:      if (cnt == 8'd3)     begin next_state = HEADER;  next_cnt = 8'd0; end
      HEADER:   if (cnt == 8'd55)    begin next_state = PAYLOAD; next_cnt = 8'd0; end
      PAYLOAD:  if (cnt == 8'd183)   begin next_state = FCS;     next_cnt = 8'd0; end
      FCS:      if (cnt == 8'd15)    begin next_state = IPG;     next_cnt = 8'd0; end
      IPG:      if (cnt == IPG_LAST) begin next_state = IDLE;    next_cnt = 8'd0; end
      default: begin
        next_state = IDLE;
        next_cnt   = 8'd0;
      end
    endcase
  end

  // Payload byte for the upcoming payload dibit: latched word, optional sequence number, zero pad
  always_comb begin
    logic [31:0] wsh;
    wsh      = word << {pay_idx[1:0], 3'b000};
    pay_byte = 8'h00;
    if (pay_idx < 6'd4) pay_byte = wsh[31:24];
`ifdef TX_SEQNUM_EN
    else if (pay_idx == 6'd4) pay_byte = seq[15:8];
    else if (pay_idx == 6'd5) pay_byte = seq[7:0];
`endif
  end

  // Dibit and strobes for the cycle being entered, so every output leaves a flop
  always_comb begin
    next_dibit = 2'b00;
    unique case (next_state)
      PREAMBLE: next_dibit = 2'b01;
      SFD:      next_dibit = (next_cnt == 8'd3) ? 2'b11 : 2'b01;
      HEADER:   next_dibit = pick_dibit(hdr_byte(next_cnt[5:2]), next_cnt[1:0]);
      PAYLOAD:  next_dibit = pick_dibit(pay_byte, next_cnt[1:0]);
      FCS:      next_dibit = (state != FCS) ? ~crc[1:0] : fcs_sh[1:0];
      default:  next_dibit = 2'b00;
    endcase
    next_txen = (next_state != IDLE) && (next_state != IPG);
    next_done = (next_state == FCS) && (next_cnt == 8'd15);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Registered outputs, word latch, running CRC and the FCS shift-out snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      axiir  <= 1'b1;
      txen   <= 1'b0;
      txd    <= 2'b00;
      done   <= 1'b0;
      word   <= 32'h0000_0000;
      crc    <= 32'hFFFF_FFFF;
      fcs_sh <= 32'h0000_0000;
    end else begin
      axiir <= (next_state == IDLE);
      txen  <= next_txen;
      txd   <= next_dibit;
      done  <= next_done;
      if (accept) begin
        word <= axiid;
        crc  <= 32'hFFFF_FFFF;
      end else if (next_state == HEADER || next_state == PAYLOAD) begin
        crc <= crc_dibit(crc, next_dibit);
      end
      if (next_state == FCS && state != FCS) fcs_sh <= {2'b00, ~crc[31:2]};
      else if (state == FCS)                 fcs_sh <= {2'b00, fcs_sh[31:2]};
    end
  end

`ifdef TX_SEQNUM_EN
  // Frame sequence number, advanced once per completed frame
  always_ff @(posedge clk) begin
    if (rst)       seq <= 16'h0000;
    else if (done) seq <= seq + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb/tb_rmii_tx_framer.sv - table-driven self-checking bench for rmii_tx_framer
`timescale 1ns/1ps
module tb_rmii_tx_framer;

  localparam logic [47:0] DEST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h6969_5A06_5491;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int          IPG   = 48;
  localparam int          FRAME = 288;
  localparam int          NVEC  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [31:0] axiid;
  logic        axiir;
  logic        txen;
  logic [1:0]  txd;
  logic        done;

  always #10 clk = ~clk;

  rmii_tx_framer #(
    .DEST_MAC  (DEST),
    .SRC_MAC   (SRC),
    .ETHERTYPE (ETYPE),
    .IPG_DIBITS(IPG)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiir(axiir),
    .txen (txen),
    .txd  (txd),
    .done (done)
  );

  typedef struct {
    logic [31:0] word;
    logic        hold;
    logic [1:0]  d0, d1, d2, d3;
  } vec_t;

  vec_t        vecs [NVEC];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] exp_seq = 16'h0000;
  logic [1:0]  dib [0:FRAME-1];
  logic [7:0]  fb  [0:FRAME/4-1];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] soft_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int n = 8; n < 68; n++)
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fb[n][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                 c = c >> 1;
      end
    return ~c;
  endfunction

  task automatic run_frame(input vec_t v, input int k);
    int           waits, ntx, first_tx, last_tx, nlow, ndone, done_at, rise_cyc, errs;
    logic [111:0] hdr_got;
    logic [15:0]  exp45;
    waits = 0; ntx = 0; first_tx = -1; last_tx = -1; nlow = 0; ndone = 0; done_at = -1;
    axiid = v.word;
    axiiv = 1'b1;
    while (!axiir && waits < 400) begin
      tick();
      axiid = v.word;
      waits++;
    end
    check($sformatf("f%0d_ready", k), axiir, 1'b1);
    check($sformatf("f%0d_txen_before", k), txen, 1'b0);
    tick();
    rise_cyc = cyc;
    axiiv = v.hold;
    for (int i = 0; i < 500; i++) begin
      if (axiir) break;
      nlow++;
      if (txen) begin
        if (first_tx < 0) first_tx = i;
        last_tx = i;
        if (ntx < FRAME) dib[ntx] = txd;
        ntx++;
      end
      if (done) begin
        ndone++;
        done_at = i;
      end
      if (v.hold) axiid = 32'hBAD0_0000 + i;
      tick();
    end
    check($sformatf("f%0d_txen_latency", k), first_tx, 0);
    check($sformatf("f%0d_txen_len", k), ntx, FRAME);
    check($sformatf("f%0d_txen_last", k), last_tx, FRAME - 1);
    check($sformatf("f%0d_ready_low", k), nlow, FRAME + IPG);
    check($sformatf("f%0d_done_count", k), ndone, 1);
    check($sformatf("f%0d_done_at", k), done_at, FRAME - 1);
    if (prev_hold) check($sformatf("f%0d_period", k), rise_cyc - last_rise, FRAME + IPG + 1);
    errs = 0;
    for (int i = 0; i < 28; i++) if (dib[i] !== 2'b01) errs++;
    check($sformatf("f%0d_preamble_errs", k), errs, 0);
    check($sformatf("f%0d_sfd", k), {dib[31], dib[30], dib[29], dib[28]}, 8'b11_01_01_01);
    check($sformatf("f%0d_pay0_dibits", k), {dib[91], dib[90], dib[89], dib[88]},
          {v.d3, v.d2, v.d1, v.d0});
    for (int n = 0; n < FRAME / 4; n++)
      fb[n] = {dib[4*n+3], dib[4*n+2], dib[4*n+1], dib[4*n]};
    hdr_got = '0;
    for (int n = 8; n < 22; n++) hdr_got = {hdr_got[103:0], fb[n]};
    check($sformatf("f%0d_header", k), hdr_got, {DEST, SRC, ETYPE});
    check($sformatf("f%0d_word", k), {fb[22], fb[23], fb[24], fb[25]}, v.word);
`ifdef TX_SEQNUM_EN
    exp45 = exp_seq;
`else
    exp45 = 16'h0000;
`endif
    check($sformatf("f%0d_bytes45", k), {fb[26], fb[27]}, exp45);
    errs = 0;
    for (int n = 28; n < 68; n++) if (fb[n] !== 8'h00) errs++;
    check($sformatf("f%0d_pad_errs", k), errs, 0);
    check($sformatf("f%0d_fcs", k), {fb[71], fb[70], fb[69], fb[68]}, soft_fcs());
    exp_seq   = exp_seq + 16'd1;
    last_rise = rise_cyc;
    prev_hold = v.hold;
  endtask

  initial begin
    int   seen;
    vec_t rec;
    vecs[0] = '{32'h0000_0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0, 2'b10, 2'b11, 2'b01, 2'b11};
    vecs[2] = '{32'h1234_5678, 1'b1, 2'b10, 2'b00, 2'b01, 2'b00};
    vecs[3] = '{32'hA5C3_0F81, 1'b1, 2'b01, 2'b01, 2'b10, 2'b10};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11};

    rst = 1'b1; axiiv = 1'b0; axiid = 32'h0;
    tick();
    tick();
    check("rst_axiir", axiir, 1'b1);
    check("rst_txen", txen, 1'b0);
    check("rst_txd", txd, 2'b00);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    exp_seq = 16'h0000;

    for (int k = 0; k < NVEC; k++) run_frame(vecs[k], k);

    // Reset and valid together: reset wins, no frame starts
    rst = 1'b1; axiiv = 1'b1; axiid = 32'h1111_1111;
    tick();
    rst = 1'b0; axiiv = 1'b0;
    check("prio_axiir", axiir, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (txen) seen++;
      tick();
    end
    check("prio_txen_seen", seen, 0);
    exp_seq = 16'h0000;

    // Reset during payload cycle 100 abandons the frame
    axiid = 32'hCAFE_F00D; axiiv = 1'b1;
    tick();
    axiiv = 1'b0;
    for (int i = 0; i < 188; i++) tick();
    check("mid_txen_before", txen, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_txen_after", txen, 1'b0);
    check("mid_done_after", done, 1'b0);
    check("mid_axiir_after", axiir, 1'b1);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (txen || done) seen++;
      tick();
    end
    check("mid_quiet", seen, 0);
    exp_seq   = 16'h0000;
    prev_hold = 1'b0;
    rec = '{32'h0BAD_CAFE, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00};
    run_frame(rec, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
